// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the scoreboarded register file.
package regfile_pkg;
    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_REGS   = 16;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: write, reserve, read and clear signals.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr1;
    logic [ADDR_WIDTH-1:0] read_addr2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  read_pending1;
    logic                  read_pending2;
    logic                  reserve_enable;
    logic [ADDR_WIDTH-1:0] reserve_addr;
    logic                  clear_start;
    logic                  clear_busy;
    logic                  write_reject;
    clr_state_e            clear_state;

    modport master (
        output write_enable, write_addr, write_data, read_addr1, read_addr2,
               reserve_enable, reserve_addr, clear_start,
        input  read_data1, read_data2, read_pending1, read_pending2,
               clear_busy, write_reject, clear_state
    );

    modport slave (
        input  write_enable, write_addr, write_data, read_addr1, read_addr2,
               reserve_enable, reserve_addr, clear_start,
        output read_data1, read_data2, read_pending1, read_pending2,
               clear_busy, write_reject, clear_state
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Sequenced clear engine: walks a pointer over every implemented entry, one per cycle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_clear_start,
    output logic                  o_clear_busy,
    output logic                  o_clear_we,
    output logic [ADDR_WIDTH-1:0] o_clear_addr,
    output clr_state_e            o_state
);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_REGS - 1);

    clr_state_e            r_state;
    clr_state_e            w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_next_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLR_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        case (r_state)
            CLR_IDLE: begin
                if (i_clear_start) begin
                    w_next_state = CLR_CLEAR;
                    w_next_ptr   = '0;
                end
            end
            CLR_CLEAR: begin
                // Start requests are ignored here; the sweep always runs to completion.
                if (r_ptr == LAST_PTR) begin
                    w_next_state = CLR_IDLE;
                    w_next_ptr   = '0;
                end else begin
                    w_next_ptr = r_ptr + 1'b1;
                end
            end
            default: begin
                w_next_state = CLR_IDLE;
                w_next_ptr   = '0;
            end
        endcase
    end

    assign o_clear_busy = (r_state == CLR_CLEAR);
    assign o_clear_we   = (r_state == CLR_CLEAR);
    assign o_clear_addr = r_ptr;
    assign o_state      = r_state;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-entry pending scoreboard and sequenced clear.
// Optional write-to-read bypass is compiled in with REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
)(
    input  logic                 clock,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pend;
    logic                  r_write_reject;

    logic                  w_clr_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_ok;
    logic                  w_rsv_ok;
    logic [DATA_WIDTH-1:0] w_rd_data1;
    logic [DATA_WIDTH-1:0] w_rd_data2;
    logic                  w_rd_pend1;
    logic                  w_rd_pend2;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    regfile_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_clear_seq (
        .clock         (clock),
        .reset         (reset),
        .i_clear_start (bus.clear_start),
        .o_clear_busy  (w_clr_busy),
        .o_clear_we    (w_clr_we),
        .o_clear_addr  (w_clr_addr),
        .o_state       (bus.clear_state)
    );

    // The clear sweep owns the array; external writes and reserves are locked out meanwhile.
    assign w_wr_ok  = bus.write_enable && addr_ok(bus.write_addr) && !w_clr_busy;
    assign w_rsv_ok = bus.reserve_enable && addr_ok(bus.reserve_addr) && !w_clr_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
            r_pend         <= '0;
            r_write_reject <= 1'b0;
        end else begin
            r_write_reject <= bus.write_enable && !w_wr_ok;
            if (w_clr_we) begin
                r_mem[w_clr_addr]  <= '0;
                r_pend[w_clr_addr] <= 1'b0;
            end
            if (w_wr_ok) begin
                r_mem[bus.write_addr]  <= bus.write_data;
                r_pend[bus.write_addr] <= 1'b0;
            end
            // Placed after the write so a same-cycle reserve leaves the entry pending.
            if (w_rsv_ok) r_pend[bus.reserve_addr] <= 1'b1;
        end
    end

    always_comb begin
        w_rd_data1 = '0;
        w_rd_pend1 = 1'b0;
        w_rd_data2 = '0;
        w_rd_pend2 = 1'b0;
        if (addr_ok(bus.read_addr1)) begin
            w_rd_data1 = r_mem[bus.read_addr1];
            w_rd_pend1 = r_pend[bus.read_addr1];
        end
        if (addr_ok(bus.read_addr2)) begin
            w_rd_data2 = r_mem[bus.read_addr2];
            w_rd_pend2 = r_pend[bus.read_addr2];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && bus.read_addr1 == bus.write_addr) begin
            w_rd_data1 = bus.write_data;
            w_rd_pend1 = w_rsv_ok && (bus.reserve_addr == bus.write_addr);
        end
        if (w_wr_ok && bus.read_addr2 == bus.write_addr) begin
            w_rd_data2 = bus.write_data;
            w_rd_pend2 = w_rsv_ok && (bus.reserve_addr == bus.write_addr);
        end
`endif
    end

    assign bus.read_data1    = w_rd_data1;
    assign bus.read_data2    = w_rd_data2;
    assign bus.read_pending1 = w_rd_pend1;
    assign bus.read_pending2 = w_rd_pend2;
    assign bus.clear_busy    = w_clr_busy;
    assign bus.write_reject  = r_write_reject;
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the 18-bit, 16-entry datapath register file: configurable width and depth, two asynchronous read ports, one synchronous write port. Adds a per-register pending scoreboard for hazard detection and a sequenced clear engine that zeroes the array one entry per cycle without asserting global reset. Sits between the decode stage (reads and reserves) and the writeback stage (writes).

## Interface
- DATA_WIDTH, 18, register width in bits
- ADDR_WIDTH, 4, register address width
- NUM_REGS, 16, implemented entries (≤ 2**ADDR_WIDTH)

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; zeroes all entries, pending bits, FSM
- write_enable  in  1  write strobe
- write_addr  in  ADDR_WIDTH  destination register
- write_data  in  DATA_WIDTH  data to store
- read_addr1 / read_addr2  in  ADDR_WIDTH  source registers
- read_data1 / read_data2  out  DATA_WIDTH  combinational read data
- read_pending1 / read_pending2  out  1  pending bit of the addressed register
- reserve_enable  in  1  mark reserve_addr pending
- reserve_addr  in  ADDR_WIDTH  register being reserved
- clear_start  in  1  launch sequenced clear
- clear_busy  out  1  clear in progress
- write_reject  out  1  registered; 1-cycle pulse when a write was dropped

## Operation
- Write: write_enable=1 at edge stores write_data at write_addr and clears its pending bit.
- Reserve: reserve_enable=1 at edge sets pending bit of reserve_addr.
- Reserve and write to same address in same cycle: data stored, pending ends 1 (reserve wins).
- Reads are combinational from storage; read_pendingN reflects the current pending bit.
- Address ≥ NUM_REGS: writes and reserves ignored (write_reject pulses for writes); reads return 0, pending 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clear_start=1 → CLEAR, clear pointer = 0, clear_busy=1 from next cycle.
  - CLEAR: each cycle zero entry[ptr] and pending[ptr], ptr+1; at ptr = NUM_REGS-1 return to IDLE after that cycle.
  - clear_start during CLEAR ignored (no restart).
  - External writes during CLEAR dropped, write_reject pulses next cycle; reserves during CLEAR ignored.
- reset takes priority over everything, including mid-clear: FSM → IDLE, pointer 0, array and pending zeroed that edge.

## Timing
- Reset values: read_data* = 0, read_pending* = 0, clear_busy = 0, write_reject = 0.
- Write-to-read latency: 1 cycle (value visible after the edge) unless bypass compiled in.
- Clear duration: exactly NUM_REGS cycles of clear_busy=1, starting the cycle after clear_start is sampled.
- write_reject: high exactly one cycle, the cycle after the dropped write edge.

## Configuration
- REGFILE_BYPASS_EN defined: when write_enable=1, write_addr valid, and read_addrN == write_addr, read_dataN = write_data combinationally and read_pendingN = 0 (unless the same cycle also reserves it); bypass suppressed during CLEAR.
- Undefined: reads return stored value only; new data visible next cycle.

## Structure
- Shared package regfile_pkg: default DATA_WIDTH/ADDR_WIDTH/NUM_REGS constants, clear FSM state encoding (IDLE=0, CLEAR=1).
- One sub-module: regfile_clear_seq (FSM plus pointer; outputs clear_busy, clear_addr, clear_we). Storage, scoreboard and read muxes stay in the top.

## Test plan
- Reset then read all 16 addresses → all read_data 0, all pending 0.
- Write 18'h2A5F5 to r3, read r3 same cycle → old 0 without bypass, 18'h2A5F5 with REGFILE_BYPASS_EN; next cycle 18'h2A5F5 both builds.
- Reserve r7, next cycle read_pending for r7 = 1; write r7 = 18'h00011 → pending 0; same-cycle reserve+write r7 → data 18'h00011 stored, pending 1.
- Fill all entries with 18'h3FFFF, pulse clear_start → clear_busy high 16 cycles; write r0 at cycle 5 → write_reject pulse, r0 stays 0; afterwards all entries 0.
- Assert reset at cycle 8 of a clear → clear_busy 0 next cycle, all entries 0, new clear_start accepted.
- NUM_REGS=12: write 18'h12345 to address 14 → write_reject pulse, read of 14 returns 0.
